wb_core_bridge: RTL

- Wishbone slave endpoint inside core_top_wrapper.
- Sits directly downstream of the management SoC Wishbone port (wbs_*) and upstream of the custom core's memory/control interface.
- Decodes MGMT accesses into a control register, a status register and a word-addressed window into core memory. The window uses a valid/ready request channel and a response channel.
- Used to load programs, release the core from reset and inspect state.

---
 rtl/wb_core_bridge.sv | 110 +++++++++++
 1 files changed

// File: rtl/wb_core_bridge.sv
// wb_core_bridge: Wishbone slave decoding CTRL/STATUS registers and a word window into core memory
//   Optional macro WB_CORE_BRIDGE_TIMEOUT_EN: abort a stalled memory access after TIMEOUT cycles
//   Ports: wb_clk_i/wb_rst_n_i   clock, asynchronous active-low reset
//          wbs_*                 Wishbone slave (single-cycle ack, read data valid with ack only)
//          core_rst_n_o/boot_o   CTRL[0]/CTRL[1]
//          mem_req_*             valid/ready request channel, payload held stable while stalled
//          mem_rsp_*             one response per request (reads and writes)
module wb_core_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int ADDR_WIDTH = 20,
  parameter int TIMEOUT = 255
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  output logic                  core_rst_n_o,
  output logic                  core_boot_o,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic                  mem_req_we_o,
  output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
  output logic [3:0]            mem_req_be_o,
  output logic [31:0]           mem_req_data_o,
  input  logic                  mem_rsp_valid_i,
  input  logic [31:0]           mem_rsp_data_i
);
  typedef enum logic [1:0] {IDLE, ACK, REQ, RSP} state_t;
  state_t state, nxt;
  logic [1:0] ctrl_q;
  logic [31:0] dat_q, reg_rd;
  logic [23:0] off;
  logic tmo_q, tmo_hit, drop_q, hit, accept, is_mem, busy, done, fin, drop_now, stat_clr;
  assign off = wbs_adr_i[23:0];
  assign is_mem = off[23];
  assign hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == BASE_ADDR[31:24]);
  assign accept = (state == IDLE) & hit;
  assign busy = (state == REQ) | (state == RSP);
  // a response completes the access in RSP, or in REQ only together with the handshake
  assign done = mem_rsp_valid_i & ((state == RSP) | ((state == REQ) & mem_req_ready_i));
  assign fin = done | tmo_hit;
  // the master abandoned the cycle: finish the memory transaction silently
  assign drop_now = drop_q | ~wbs_cyc_i;
  assign stat_clr = accept & wbs_we_i & wbs_sel_i[0] & (off == 24'h4) & wbs_dat_i[1];
  assign reg_rd = (off == 24'h0) ? {30'b0, ctrl_q} :
                  (off == 24'h4) ? {16'hC0DE, 14'b0, tmo_q, ctrl_q[0]} : '0;
  assign core_rst_n_o = ctrl_q[0];
  assign core_boot_o = ctrl_q[1];
`ifdef WB_CORE_BRIDGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i)
    if (!wb_rst_n_i) cnt_q <= '0;
    else if (accept) cnt_q <= '0;
    else if (busy) cnt_q <= cnt_q + 1'b1;
  assign tmo_hit = busy & ~done & (cnt_q == CW'(TIMEOUT - 1));
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i)
    if (!wb_rst_n_i) tmo_q <= 1'b0;
    else if (tmo_hit) tmo_q <= 1'b1;
    else if (stat_clr) tmo_q <= 1'b0;
`else
  assign tmo_hit = 1'b0;
  assign tmo_q = 1'b0;
`endif
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i)
    if (!wb_rst_n_i) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = (state == IDLE) ? (accept ? (is_mem ? REQ : ACK) : IDLE) :
          (state == ACK) ? IDLE :
          fin ? (drop_now ? IDLE : ACK) :
          ((state == REQ) & mem_req_ready_i) ? RSP : state;
  end
  always_comb begin
    wbs_ack_o = state == ACK;
    wbs_dat_o = (state == ACK) ? dat_q : '0;
    mem_req_valid_o = state == REQ;
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i)
    if (!wb_rst_n_i) begin
      ctrl_q <= '0;
      dat_q <= '0;
      drop_q <= 1'b0;
      mem_req_we_o <= 1'b0;
      mem_req_addr_o <= '0;
      mem_req_be_o <= '0;
      mem_req_data_o <= '0;
    end else begin
      if (accept) begin
        drop_q <= 1'b0;
        dat_q <= wbs_we_i ? '0 : reg_rd;
        if (wbs_we_i & wbs_sel_i[0] & (off == 24'h0)) ctrl_q <= wbs_dat_i[1:0];
        if (is_mem) begin
          mem_req_we_o <= wbs_we_i;
          mem_req_addr_o <= wbs_adr_i[ADDR_WIDTH+1:2];
          mem_req_be_o <= wbs_sel_i;
          mem_req_data_o <= wbs_dat_i;
        end
      end
      if (busy & ~wbs_cyc_i) drop_q <= 1'b1;
      if (done) dat_q <= mem_req_we_o ? '0 : mem_rsp_data_i;
      else if (tmo_hit) dat_q <= 32'hDEAD_BEEF;
    end
endmodule
